// File: rtl/otbn_pq_pkg.sv
// Shared types and constants for the PQ vector issuer and the PQ ALU.
// pq_vop_predec is the single source of the blanker enables for both sides.
package otbn_pq_pkg;

   localparam int PQLEN    = 32;
   localparam int NLANES   = 8;
   localparam int WLEN     = PQLEN * NLANES;
   localparam int LaneSelW = $clog2(NLANES);

   typedef enum logic [2:0] {
      PqVopAdd   = 3'd0,
      PqVopSub   = 3'd1,
      PqVopMul   = 3'd2,
      PqVopScale = 3'd3,
      PqVopBfCt  = 3'd4,
      PqVopBfGs  = 3'd5
   } pq_vop_e;

   localparam logic [7:0] AluOpPqNone        = 8'h00;
   localparam logic [7:0] AluOpPqAdd         = 8'h01;
   localparam logic [7:0] AluOpPqSub         = 8'h02;
   localparam logic [7:0] AluOpPqMul         = 8'h03;
   localparam logic [7:0] AluOpPqScale       = 8'h04;
   localparam logic [7:0] AluOpPqButterflyCT = 8'h05;
   localparam logic [7:0] AluOpPqButterflyGS = 8'h06;

   typedef struct packed {
      logic add_op_en;
      logic mul_op_en;
      logic gs_sub_op_en;
      logic ct_sub_op_en;
   } alu_predec_pq_t;

   function automatic alu_predec_pq_t pq_vop_predec(pq_vop_e op);
      alu_predec_pq_t p;
      p = '0;
      case (op)
         PqVopAdd:   p.add_op_en = 1'b1;
         PqVopSub:   p.ct_sub_op_en = 1'b1;
         PqVopMul,
         PqVopScale: p.mul_op_en = 1'b1;
         PqVopBfCt: begin
            p.ct_sub_op_en = 1'b1;
            p.mul_op_en    = 1'b1;
            p.add_op_en    = 1'b1;
         end
         PqVopBfGs: begin
            p.gs_sub_op_en = 1'b1;
            p.mul_op_en    = 1'b1;
            p.add_op_en    = 1'b1;
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   function automatic logic [7:0] pq_vop_aluop(pq_vop_e op);
      logic [7:0] code;
      case (op)
         PqVopAdd:   code = AluOpPqAdd;
         PqVopSub:   code = AluOpPqSub;
         PqVopMul:   code = AluOpPqMul;
         PqVopScale: code = AluOpPqScale;
         PqVopBfCt:  code = AluOpPqButterflyCT;
         PqVopBfGs:  code = AluOpPqButterflyGS;
         default:    code = AluOpPqNone;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/otbn_pq_lane_merge.sv
// Inserts one PQLEN-bit lane of src into buf, leaving every other lane of buf untouched.
module otbn_pq_lane_merge
   import otbn_pq_pkg::*;
(
   input  logic [LaneSelW-1:0] lane_i,
   input  logic [WLEN-1:0]     src_i,
   input  logic [WLEN-1:0]     buf_i,
   output logic [WLEN-1:0]     buf_o
);

   logic [WLEN-1:0] laneMask;

   assign laneMask = {{(WLEN - PQLEN){1'b0}}, {PQLEN{1'b1}}} << (lane_i * PQLEN);
   assign buf_o    = (buf_i & ~laneMask) | (src_i & laneMask);

endmodule

// File: rtl/otbn_pq_vec_issuer.sv
// Issues a vector PQ instruction to the combinational PQ ALU one lane per cycle
// and collects the lane-placed rs0/rs1 results for WDR write-back.
module otbn_pq_vec_issuer
   import otbn_pq_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  pq_vop_e             op_sel_i,
   input  logic [LaneSelW-1:0] a_start_i,
   input  logic [LaneSelW-1:0] b_start_i,
   input  logic [LaneSelW-1:0] d_start_i,
   input  logic [3:0]          len_i,
   input  logic                stall_i,
   output logic [7:0]          op_o,
   output logic [LaneSelW-1:0] operand_a_w_sel_o,
   output logic [LaneSelW-1:0] operand_b_w_sel_o,
   output logic [LaneSelW-1:0] d_w_sel_o,
   output alu_predec_pq_t      alu_predec_pq_o,
   input  logic [WLEN-1:0]     alu_rs0_i,
   input  logic [WLEN-1:0]     alu_rs1_i,
   input  logic                alu_predec_error_i,
   output logic                busy_o,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [WLEN-1:0]     res_rs0_o,
   output logic [WLEN-1:0]     res_rs1_o,
   output logic                err_o
);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp,
      StErr
   } state_e;

   state_e              state_q;
   pq_vop_e             vop_q;
   logic [LaneSelW-1:0] aStart_q, bStart_q, dStart_q;
   logic [3:0]          len_q, laneCnt_q;
   logic [WLEN-1:0]     rs0Buf_q, rs1Buf_q;
   logic [WLEN-1:0]     rs0Buf_d, rs1Buf_d;
   logic                busy_q, valid_q, err_q;
   logic                issuing, lastLane;
   logic [LaneSelW-1:0] laneOff;

   assign issuing  = (state_q == StIssue);
   assign laneOff  = laneCnt_q[LaneSelW-1:0];
   assign lastLane = (laneCnt_q == len_q - 4'd1);

   // Lane selects wrap naturally through the 3-bit adders.
   assign operand_a_w_sel_o = issuing ? aStart_q + laneOff : '0;
   assign operand_b_w_sel_o = issuing ? bStart_q + laneOff : '0;
   assign d_w_sel_o         = issuing ? dStart_q + laneOff : '0;
   assign op_o              = issuing ? pq_vop_aluop(vop_q) : AluOpPqNone;
   assign alu_predec_pq_o   = issuing ? pq_vop_predec(vop_q) : '0;

   otbn_pq_lane_merge u_merge_rs0 (
      .lane_i (d_w_sel_o),
      .src_i  (alu_rs0_i),
      .buf_i  (rs0Buf_q),
      .buf_o  (rs0Buf_d)
   );

   otbn_pq_lane_merge u_merge_rs1 (
      .lane_i (d_w_sel_o),
      .src_i  (alu_rs1_i),
      .buf_i  (rs1Buf_q),
      .buf_o  (rs1Buf_d)
   );

   // Error beats stall, and stall beats capture/completion.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         vop_q     <= PqVopAdd;
         aStart_q  <= '0;
         bStart_q  <= '0;
         dStart_q  <= '0;
         len_q     <= '0;
         laneCnt_q <= '0;
         rs0Buf_q  <= '0;
         rs1Buf_q  <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  vop_q     <= op_sel_i;
                  aStart_q  <= a_start_i;
                  bStart_q  <= b_start_i;
                  dStart_q  <= d_start_i;
                  len_q     <= (len_i > 4'(NLANES)) ? 4'(NLANES) : len_i;
                  laneCnt_q <= '0;
                  rs0Buf_q  <= '0;
                  rs1Buf_q  <= '0;
                  err_q     <= 1'b0;
                  busy_q    <= 1'b1;
                  if (len_i != 4'd0) begin
                     state_q <= StIssue;
                  end else begin
                     state_q <= StResp;
                     valid_q <= 1'b1;
                  end
               end
            end
            StIssue: begin
               if (alu_predec_error_i) begin
                  state_q  <= StErr;
                  err_q    <= 1'b1;
                  busy_q   <= 1'b0;
                  rs0Buf_q <= '0;
                  rs1Buf_q <= '0;
               end else if (!stall_i) begin
                  rs0Buf_q <= rs0Buf_d;
                  rs1Buf_q <= rs1Buf_d;
                  if (lastLane) begin
                     state_q <= StResp;
                     valid_q <= 1'b1;
                  end else begin
                     laneCnt_q <= laneCnt_q + 4'd1;
                  end
               end
            end
            StResp: begin
               if (res_ready_i) begin
                  state_q <= StIdle;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            StErr: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign res_valid_o = valid_q;
   assign res_rs0_o   = rs0Buf_q;
   assign res_rs1_o   = rs1Buf_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_otbn_pq_vec_issuer.sv
// Scoreboard bench for otbn_pq_vec_issuer with a behavioural PQ ALU stub
// and randomized WDR operands.
module tb_otbn_pq_vec_issuer;
   import otbn_pq_pkg::*;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           start_i = 1'b0;
   pq_vop_e        op_sel_i = PqVopAdd;
   logic [2:0]     a_start_i = '0, b_start_i = '0, d_start_i = '0;
   logic [3:0]     len_i = '0;
   logic           stall_i = 1'b0;
   logic [7:0]     op_o;
   logic [2:0]     operand_a_w_sel_o, operand_b_w_sel_o, d_w_sel_o;
   alu_predec_pq_t alu_predec_pq_o;
   logic [255:0]   alu_rs0_i, alu_rs1_i;
   logic           alu_predec_error_i = 1'b0;
   logic           busy_o, res_valid_o, err_o;
   logic           res_ready_i = 1'b1;
   logic [255:0]   res_rs0_o, res_rs1_o;

   typedef struct {
      logic [255:0] rs0;
      logic [255:0] rs1;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] wdrA[8];
   logic [31:0] wdrB[8];
   int          checks = 0;
   int          failures = 0;

   otbn_pq_vec_issuer dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .start_i            (start_i),
      .op_sel_i           (op_sel_i),
      .a_start_i          (a_start_i),
      .b_start_i          (b_start_i),
      .d_start_i          (d_start_i),
      .len_i              (len_i),
      .stall_i            (stall_i),
      .op_o               (op_o),
      .operand_a_w_sel_o  (operand_a_w_sel_o),
      .operand_b_w_sel_o  (operand_b_w_sel_o),
      .d_w_sel_o          (d_w_sel_o),
      .alu_predec_pq_o    (alu_predec_pq_o),
      .alu_rs0_i          (alu_rs0_i),
      .alu_rs1_i          (alu_rs1_i),
      .alu_predec_error_i (alu_predec_error_i),
      .busy_o             (busy_o),
      .res_valid_o        (res_valid_o),
      .res_ready_i        (res_ready_i),
      .res_rs0_o          (res_rs0_o),
      .res_rs1_o          (res_rs1_o),
      .err_o              (err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] expOp(int vop);
      case (vop)
         0: return AluOpPqAdd;
         1: return AluOpPqSub;
         2: return AluOpPqMul;
         3: return AluOpPqScale;
         4: return AluOpPqButterflyCT;
         5: return AluOpPqButterflyGS;
         default: return AluOpPqNone;
      endcase
   endfunction

   // Enables as {add, mul, gs_sub, ct_sub}.
   function automatic logic [3:0] expPredec(int vop);
      case (vop)
         0: return 4'b1000;
         1: return 4'b0001;
         2, 3: return 4'b0100;
         4: return 4'b1101;
         5: return 4'b1110;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] aluFn0(logic [7:0] opc, logic [31:0] a, logic [31:0] b);
      case (opc)
         AluOpPqAdd, AluOpPqButterflyCT: return a + b;
         AluOpPqSub, AluOpPqButterflyGS: return a - b;
         AluOpPqMul:   return a * b;
         AluOpPqScale: return a * b + 32'd1;
         default:      return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] aluFn1(logic [7:0] opc, logic [31:0] a, logic [31:0] b);
      case (opc)
         AluOpPqButterflyCT: return a - b;
         AluOpPqButterflyGS: return (a - b) * 32'd3;
         AluOpPqNone:        return 32'd0;
         default:            return a ^ b;
      endcase
   endfunction

   // Combinational ALU stub: result placed only in the destination lane.
   always_comb begin
      alu_rs0_i = '0;
      alu_rs1_i = '0;
      if (op_o != AluOpPqNone) begin
         alu_rs0_i[int'(d_w_sel_o)*32 +: 32] = aluFn0(op_o, wdrA[operand_a_w_sel_o], wdrB[operand_b_w_sel_o]);
         alu_rs1_i[int'(d_w_sel_o)*32 +: 32] = aluFn1(op_o, wdrA[operand_a_w_sel_o], wdrB[operand_b_w_sel_o]);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every cycle a result is presented it must match the head entry.
   always @(negedge clk_i) begin
      if (rst_ni && res_valid_o) begin
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_valid actual=1 required=0");
         end else if (res_rs0_o !== expQ[0].rs0 || res_rs1_o !== expQ[0].rs1) begin
            failures++;
            $display("[TB] FAIL result_buffers actual=%h/%h required=%h/%h",
                     res_rs0_o, res_rs1_o, expQ[0].rs0, expQ[0].rs1);
         end
         if (expQ.size() != 0 && res_ready_i) void'(expQ.pop_front());
      end
   end

   task automatic applyStimulus(input int vop, input int aS, input int bS, input int dS, input int len,
                                input int stallAt, input int stallLen, input int errAt, input int readyDelay);
      int   lenEff, busyCycles, respCycles, captures, stalled, expBusy;
      bit   done, errHit, issuingNow, stallNow, errNow;
      exp_t e;
      logic [7:0] opc;
      lenEff = (len > 8) ? 8 : len;
      opc    = expOp(vop);
      for (int i = 0; i < 8; i++) begin
         wdrA[i] = $urandom;
         wdrB[i] = $urandom;
      end
      e.rs0 = '0;
      e.rs1 = '0;
      for (int i = 0; i < lenEff; i++) begin
         e.rs0[((dS + i) % 8)*32 +: 32] = aluFn0(opc, wdrA[(aS + i) % 8], wdrB[(bS + i) % 8]);
         e.rs1[((dS + i) % 8)*32 +: 32] = aluFn1(opc, wdrA[(aS + i) % 8], wdrB[(bS + i) % 8]);
      end
      if (errAt >= lenEff) expQ.push_back(e);

      @(posedge clk_i); #1;
      start_i   = 1'b1;
      op_sel_i  = pq_vop_e'(vop);
      a_start_i = 3'(aS);
      b_start_i = 3'(bS);
      d_start_i = 3'(dS);
      len_i     = 4'(len);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      checkOutput("err_clear_on_start", 32'(err_o), 32'd0);

      busyCycles = 0; respCycles = 0; captures = 0; stalled = 0;
      done = 1'b0; errHit = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         if (!busy_o) begin
            done = 1'b1;
         end else begin
            busyCycles++;
            issuingNow = (op_o != AluOpPqNone);
            stallNow = 1'b0;
            errNow = 1'b0;
            if (issuingNow) begin
               stallNow = (captures == stallAt) && (stalled < stallLen);
               errNow   = (captures == errAt);
               stall_i  = stallNow;
               alu_predec_error_i = errNow;
               start_i  = 1'($urandom_range(0, 1));
               len_i    = 4'($urandom_range(1, 8));
               checkOutput("op_code", 32'(op_o), 32'(opc));
               checkOutput("predec", 32'(alu_predec_pq_o), 32'(expPredec(vop)));
               checkOutput("sel_a", 32'(operand_a_w_sel_o), 32'((aS + captures) % 8));
               checkOutput("sel_b", 32'(operand_b_w_sel_o), 32'((bS + captures) % 8));
               checkOutput("sel_d", 32'(d_w_sel_o), 32'((dS + captures) % 8));
            end else begin
               checkOutput("resp_predec_off", 32'(alu_predec_pq_o), 32'd0);
               stall_i = 1'b0;
               alu_predec_error_i = 1'($urandom_range(0, 1));
               res_ready_i = (respCycles >= readyDelay);
               start_i = (respCycles < readyDelay) ? 1'($urandom_range(0, 1)) : 1'b0;
               respCycles++;
            end
            @(posedge clk_i); #1;
            if (issuingNow) begin
               if (errNow) errHit = 1'b1;
               else if (stallNow) stalled++;
               else captures++;
            end
         end
      end
      stall_i = 1'b0; alu_predec_error_i = 1'b0; start_i = 1'b0; res_ready_i = 1'b1;
      if (!done) begin
         failures++;
         $display("[TB] FAIL timeout actual=busy required=idle");
      end

      if (errAt < lenEff) begin
         expBusy = errAt + 1;
         checkOutput("err_hit", 32'(errHit), 32'd1);
         checkOutput("err_set", 32'(err_o), 32'd1);
         checkOutput("err_no_valid", 32'(res_valid_o), 32'd0);
         @(posedge clk_i); #1;
         checkOutput("err_sticky", 32'(err_o), 32'd1);
         checkOutput("err_idle_op", 32'(op_o), 32'(AluOpPqNone));
      end else begin
         expBusy = lenEff + ((stallAt < lenEff) ? stallLen : 0) + 1 + readyDelay;
         checkOutput("captures", 32'(captures), 32'(lenEff));
         checkOutput("err_low", 32'(err_o), 32'd0);
      end
      checkOutput("busy_cycles", 32'(busyCycles), 32'(expBusy));
   endtask

   initial begin
      rst_ni = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wdrA[i] = '0;
         wdrB[i] = '0;
      end
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_valid", 32'(res_valid_o), 32'd0);
      checkOutput("rst_err", 32'(err_o), 32'd0);
      checkOutput("rst_op", 32'(op_o), 32'(AluOpPqNone));
      checkOutput("rst_predec", 32'(alu_predec_pq_o), 32'd0);
      checkOutput("rst_sel_d", 32'(d_w_sel_o), 32'd0);
      checkOutput("rst_buf", 32'(res_rs0_o != '0 || res_rs1_o != '0), 32'd0);
      rst_ni = 1'b1;

      applyStimulus(4, 0, 0, 0, 8, 99, 0, 99, 0);
      applyStimulus(0, 6, 3, 7, 4, 99, 0, 99, 0);
      applyStimulus(2, 2, 5, 1, 3, 1, 2, 99, 0);
      applyStimulus(1, 3, 3, 3, 0, 99, 0, 99, 0);
      applyStimulus(3, 1, 7, 4, 12, 99, 0, 99, 0);
      applyStimulus(5, 0, 1, 2, 8, 99, 0, 4, 0);
      applyStimulus(1, 5, 2, 6, 6, 99, 0, 99, 0);
      applyStimulus(3, 4, 0, 5, 5, 99, 0, 99, 5);
      for (int n = 0; n < 12; n++) begin
         applyStimulus(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 2)), 99, int'($urandom_range(0, 3)));
      end

      // Reset in the middle of an operation must leave no result behind.
      @(posedge clk_i); #1;
      start_i = 1'b1; op_sel_i = PqVopAdd; len_i = 4'd8;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      checkOutput("midrst_busy", 32'(busy_o), 32'd0);
      checkOutput("midrst_op", 32'(op_o), 32'(AluOpPqNone));
      rst_ni = 1'b1;
      repeat (10) @(posedge clk_i);
      #1;
      checkOutput("midrst_no_valid", 32'(res_valid_o), 32'd0);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/otbn_pq_vec_issuer.md
Name: otbn_pq_vec_issuer

Overview:
Initiator side of the PQ ALU operation interface. It takes one vector PQ instruction (operation class, start lanes, lane count) and issues it to the combinational PQ ALU one 32-bit lane per cycle. For each lane it drives the op code, the lane selects and the matching predecoded blanker enables. It merges the lane-placed rs0/rs1 results returned by the ALU into two 256-bit buffers, then hands them to WDR write-back with a valid/ready handshake.

Parameters:
PQLEN, 32, lane width in bits
NLANES, 8, lanes per WDR (WLEN/PQLEN); the lane select width is clog2(NLANES)=3

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
start_i  in  1  single-cycle command strobe; accepted only in IDLE
op_sel_i  in  3  pq_vop_e: ADD, SUB, MUL, SCALE, BF_CT, BF_GS
a_start_i  in  3  first lane of operand a
b_start_i  in  3  first lane of operand b
d_start_i  in  3  first lane of destination
len_i  in  4  lanes to process; 0 = none; values >8 clamp to 8
stall_i  in  1  hold the current lane (datapath or WDR port busy)
op_o  out  8  ALU op code (package AluOpPq* constant)
operand_a_w_sel_o  out  3  lane select, operand a
operand_b_w_sel_o  out  3  lane select, operand b
d_w_sel_o  out  3  lane select, destination
alu_predec_pq_o  out  struct  {add_op_en, mul_op_en, gs_sub_op_en, ct_sub_op_en}
alu_rs0_i  in  256  ALU rs0_o; only the lane at d_w_sel is non-zero
alu_rs1_i  in  256  ALU rs1_o
alu_predec_error_i  in  1  ALU predecode mismatch flag
busy_o  out  1  high in ISSUE and RESP
res_valid_o  out  1  result buffers valid
res_ready_i  in  1  write-back accepts the result
res_rs0_o  out  256  merged rs0 buffer
res_rs1_o  out  256  merged rs1 buffer
err_o  out  1  sticky predecode error

Behaviour:
- Reset values: state IDLE; counter 0; buffers 0; busy_o=0, res_valid_o=0, err_o=0. Reset mid-operation abandons the command with no partial res_valid_o.
- FSM states: IDLE, ISSUE, RESP, ERR.
- IDLE:
  - op_o=AluOpPqNone, all predec enables 0, so all ALU operands stay blanked; lane selects are 0.
  - On start_i: latch the op and three start lanes, store len as min(len_i,8), clear both buffers and err_o.
  - Next state: ISSUE if len>0, else RESP.
- ISSUE:
  - Lane counter i runs 0..len-1.
  - Selects are combinational from registers: a=(a_start+i) mod 8, b=(b_start+i) mod 8, d=(d_start+i) mod 8. Wrap-around is the natural 3-bit overflow.
  - op_o = constant mapped from the latched op. Predec enables come from the same table the ALU checks: ADD add; SUB ct_sub; MUL and SCALE mul; BF_CT ct_sub+mul+add; BF_GS gs_sub+mul+add.
  - The ALU is combinational, so a lane's result is captured in the same cycle it is issued. Capture happens on cycles with stall_i=0: buf = (buf & ~M) | (alu & M), where M is the 32-bit mask at lane d. Both buffers update.
  - stall_i=1: i, buffers and outputs hold; op and enables stay driven.
  - After the last lane is captured, go to RESP; the lane count is exactly len.
  - Repeated destination lanes (len=8 covers every lane once, so no overlap) cannot occur.
- RESP:
  - op_o=None, enables 0; res_valid_o=1.
  - Buffers hold until res_valid_o && res_ready_i, then go to IDLE.
  - start_i while busy is ignored and not queued.
- Errors:
  - alu_predec_error_i=1 in ISSUE: go to ERR, set err_o, discard buffers, raise no res_valid_o.
  - ERR drives op None with enables 0 and goes to IDLE the next cycle.
  - err_o stays high until the next accepted start_i.
  - alu_predec_error_i is ignored outside ISSUE.
- Same-cycle events: stall_i takes priority over capture. An error takes priority over stall and over completion.

Decomposition:
- otbn_pq_pkg holds the following:
  - pq_vop_e;
  - the AluOpPq* constants, reused unchanged;
  - alu_predec_pq_t;
  - a function pq_vop_predec(pq_vop_e) returning the enable struct, shared with the ALU checker so the two sides cannot diverge;
  - NLANES.
- One natural sub-module, otbn_pq_lane_merge: a masked 256-bit lane insert (lane index, source, buffer) -> buffer, instantiated twice.

Test Plan:
- BF_CT, a=0, b=0, d=0, len=8, no stall: 8 issue cycles with selects 0..7 and op AluOpPqButterflyCT, enables {1,1,0,1}. Then res_valid_o with both buffers equal to the per-lane reference model; busy_o high for 9 cycles.
- ADD, a=6, b=3, d=7, len=4: selects a 6,7,0,1; b 3,4,5,6; d 7,0,1,2. Only lanes 7,0,1,2 of res_rs0_o are non-zero; other lanes are 0.
- MUL, len=3, stall_i high on the 2nd issue cycle for 2 cycles: lane 1 selects are held for 3 cycles, there is one capture per lane, and the total is 5 issue cycles.
- len_i=0, then len_i=12: the first goes IDLE→RESP next cycle with zero buffers; the second processes exactly 8 lanes.
- GS, len=8, alu_predec_error_i forced at lane 4: ERR then IDLE, err_o=1, no res_valid_o. The next start clears err_o.
- res_ready_i held low 5 cycles: res_valid_o and buffers stable, and start_i pulses during the hold are ignored.
